// File: rtl/bop_pkg.sv
// Shared types and defaults for the overflow-range (bop) write path.
package bop_pkg;

  localparam int unsigned BOP_NUM_ENTRIES = 8;
  localparam int unsigned BOP_ADDR_W      = 32;

  typedef struct packed {
    logic [BOP_ADDR_W-1:0] first;
    logic [BOP_ADDR_W-1:0] last;
  } range_t;

  typedef enum logic [0:0] {
    StIdle,
    StFlush
  } ctrl_state_e;

endpackage

// File: rtl/bop_rr_arb.sv
// Round-robin arbiter: one-hot combinational grant, search starts at the registered pointer.
module bop_rr_arb #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] hi_req;
  logic               found;

  // Requests at or above the pointer win first; otherwise wrap to the lowest index.
  always_comb begin
    hi_req = '0;
    gnt_o  = '0;
    found  = 1'b0;
    ptr_d  = ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      hi_req[i] = req_i[i] && (i >= 32'(ptr_q));
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (en_i && !found && hi_req[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        ptr_d    = (i == NUM_REQ - 1) ? '0 : PtrW'(i + 1);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (en_i && !found && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        ptr_d    = (i == NUM_REQ - 1) ? '0 : PtrW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bop_range_write_ctrl.sv
// Arbitrates monitor range commits onto the overflow-range buffer write port; drops
// malformed/duplicate ranges and sequences a one-entry-per-cycle flush.
module bop_range_write_ctrl
  import bop_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned NUM_ENTRIES = BOP_NUM_ENTRIES,
  parameter int unsigned ADDR_W      = BOP_ADDR_W
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*ADDR_W-1:0]      first_i,
  input  logic [NUM_REQ*ADDR_W-1:0]      last_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  input  logic                           flush_i,
  output logic                           flush_busy_o,
  output logic                           buf_we_o,
  output logic [$clog2(NUM_ENTRIES)-1:0] buf_idx_o,
  output logic                           buf_valid_o,
  output logic [ADDR_W-1:0]              buf_first_o,
  output logic [ADDR_W-1:0]              buf_last_o,
  output logic [$clog2(NUM_ENTRIES):0]   occupancy_o,
  output logic [15:0]                    drop_cnt_o
);

  localparam int unsigned IdxW = $clog2(NUM_ENTRIES);
  localparam int unsigned OccW = IdxW + 1;

  ctrl_state_e state_q, state_d;

  logic [NUM_REQ-1:0] gnt;
  logic               arb_en;
  logic [ADDR_W-1:0]  sel_first, sel_last;
  logic               granted, malformed, dup, do_write, do_drop;
  logic               flush_start, flush_done;

  logic              buf_we_q, buf_valid_q;
  logic [IdxW-1:0]   buf_idx_q, wr_ptr_q;
  logic [ADDR_W-1:0] buf_first_q, buf_last_q;
  logic [OccW-1:0]   occ_q;
  logic [15:0]       drop_cnt_q;
  logic [ADDR_W-1:0] lr_first_q, lr_last_q;
  logic              lr_valid_q;

  // A same-cycle flush request takes priority over any pending commit.
  assign arb_en = (state_q == StIdle) && !flush_i;

  bop_rr_arb #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_i(req_i),
    .en_i (arb_en),
    .gnt_o(gnt)
  );

  always_comb begin
    sel_first = '0;
    sel_last  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_first = first_i[i*ADDR_W +: ADDR_W];
        sel_last  = last_i[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign granted     = |gnt;
  assign malformed   = sel_last < sel_first;
  assign dup         = lr_valid_q && (sel_first == lr_first_q) && (sel_last == lr_last_q);
  assign do_write    = granted && !malformed && !dup;
  assign do_drop     = granted && !do_write;
  assign flush_start = (state_q == StIdle) && flush_i;
  // buf_idx_q doubles as the flush counter while in StFlush.
  assign flush_done  = (state_q == StFlush) && (buf_idx_q == IdxW'(NUM_ENTRIES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (flush_i) state_d = StFlush;
      StFlush: if (flush_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      buf_we_q    <= 1'b0;
      buf_idx_q   <= '0;
      buf_valid_q <= 1'b0;
      buf_first_q <= '0;
      buf_last_q  <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      drop_cnt_q  <= '0;
      lr_first_q  <= '0;
      lr_last_q   <= '0;
      lr_valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_we_q <= 1'b0;
      if (do_write) begin
        buf_we_q    <= 1'b1;
        buf_idx_q   <= wr_ptr_q;
        buf_valid_q <= 1'b1;
        buf_first_q <= sel_first;
        buf_last_q  <= sel_last;
        wr_ptr_q    <= wr_ptr_q + IdxW'(1);
        if (occ_q < OccW'(NUM_ENTRIES)) occ_q <= occ_q + OccW'(1);
        lr_first_q  <= sel_first;
        lr_last_q   <= sel_last;
        lr_valid_q  <= 1'b1;
      end else if (flush_start) begin
        buf_we_q    <= 1'b1;
        buf_idx_q   <= '0;
        buf_valid_q <= 1'b0;
        buf_first_q <= '0;
        buf_last_q  <= '0;
      end else if (state_q == StFlush && !flush_done) begin
        buf_we_q    <= 1'b1;
        buf_idx_q   <= buf_idx_q + IdxW'(1);
        buf_valid_q <= 1'b0;
        buf_first_q <= '0;
        buf_last_q  <= '0;
      end
      if (flush_done) begin
        wr_ptr_q   <= '0;
        occ_q      <= '0;
        lr_valid_q <= 1'b0;
      end
      if (do_drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign gnt_o        = gnt;
  assign flush_busy_o = (state_q == StFlush);
  assign buf_we_o     = buf_we_q;
  assign buf_idx_o    = buf_idx_q;
  assign buf_valid_o  = buf_valid_q;
  assign buf_first_o  = buf_first_q;
  assign buf_last_o   = buf_last_q;
  assign occupancy_o  = occ_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_bop_range_write_ctrl.sv
// Directed self-checking bench for bop_range_write_ctrl (2 requesters, 8 entries, 32-bit ranges).
module tb_bop_range_write_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [63:0] first;
  logic [63:0] last;
  logic [1:0]  gnt;
  logic        flush;
  logic        busy;
  logic        we;
  logic [2:0]  idx;
  logic        valid;
  logic [31:0] bfirst;
  logic [31:0] blast;
  logic [3:0]  occ;
  logic [15:0] drops;

  int total = 0;
  int bad   = 0;

  bop_range_write_ctrl #(
    .NUM_REQ    (2),
    .NUM_ENTRIES(8),
    .ADDR_W     (32)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .first_i     (first),
    .last_i      (last),
    .gnt_o       (gnt),
    .flush_i     (flush),
    .flush_busy_o(busy),
    .buf_we_o    (we),
    .buf_idx_o   (idx),
    .buf_valid_o (valid),
    .buf_first_o (bfirst),
    .buf_last_o  (blast),
    .occupancy_o (occ),
    .drop_cnt_o  (drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rng(input int r, input logic [31:0] f, input logic [31:0] l);
    first[r*32 +: 32] = f;
    last[r*32 +: 32]  = l;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_gnt"}, 64'(gnt), 64'h0);
    chk({pfx, "_busy"}, 64'(busy), 64'h0);
    chk({pfx, "_we"}, 64'(we), 64'h0);
    chk({pfx, "_idx"}, 64'(idx), 64'h0);
    chk({pfx, "_valid"}, 64'(valid), 64'h0);
    chk({pfx, "_first"}, 64'(bfirst), 64'h0);
    chk({pfx, "_last"}, 64'(blast), 64'h0);
    chk({pfx, "_occ"}, 64'(occ), 64'h0);
    chk({pfx, "_drop"}, 64'(drops), 64'h0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = 2'b00;
    flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    first = '0;
    last  = '0;
    flush = 1'b0;

    // Reset state
    do_reset();
    chk_reset("rst");

    // 1: single request, grant same cycle, write next cycle
    req = 2'b01;
    set_rng(0, 32'h1000, 32'h1027);
    #1 chk("t1_gnt", 64'(gnt), 64'h1);
    tick();
    req = 2'b00;
    chk("t1_we", 64'(we), 64'h1);
    chk("t1_idx", 64'(idx), 64'h0);
    chk("t1_valid", 64'(valid), 64'h1);
    chk("t1_first", 64'(bfirst), 64'h1000);
    chk("t1_last", 64'(blast), 64'h1027);
    chk("t1_occ", 64'(occ), 64'h1);

    // 2: contention, alternating grants from a fresh pointer
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_rng(0, 32'h3000 + 32'(k) * 32'h100, 32'h300F + 32'(k) * 32'h100);
      set_rng(1, 32'h4000 + 32'(k) * 32'h100, 32'h400F + 32'(k) * 32'h100);
      req = 2'b11;
      #1 chk($sformatf("t2_gnt%0d", k), 64'(gnt), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      chk($sformatf("t2_we%0d", k), 64'(we), 64'h1);
      chk($sformatf("t2_idx%0d", k), 64'(idx), 64'(k));
      chk($sformatf("t2_first%0d", k), 64'(bfirst),
          64'((k % 2 == 0) ? 32'h3000 : 32'h4000) + 64'(k) * 64'h100);
    end
    req = 2'b00;
    chk("t2_occ", 64'(occ), 64'h4);

    // 3: wrap past 8 entries, occupancy saturates
    do_reset();
    for (int k = 0; k < 10; k++) begin
      set_rng(0, 32'h5000 + 32'(k) * 32'h40, 32'h503F + 32'(k) * 32'h40);
      req = 2'b01;
      tick();
      chk($sformatf("t3_idx%0d", k), 64'(idx), 64'(k % 8));
      chk($sformatf("t3_occ%0d", k), 64'(occ), (k + 1 > 8) ? 64'h8 : 64'(k + 1));
    end
    req = 2'b00;

    // 4: malformed range, then duplicate
    set_rng(0, 32'h2000, 32'h1FFF);
    req = 2'b01;
    #1 chk("t4_gnt_bad", 64'(gnt), 64'h1);
    tick();
    chk("t4_we_bad", 64'(we), 64'h0);
    chk("t4_drop1", 64'(drops), 64'h1);
    set_rng(0, 32'h6000, 32'h60FF);
    tick();
    chk("t4_we_ok", 64'(we), 64'h1);
    chk("t4_idx_ok", 64'(idx), 64'h2);
    tick();
    req = 2'b00;
    chk("t4_we_dup", 64'(we), 64'h0);
    chk("t4_drop2", 64'(drops), 64'h2);
    chk("t4_occ", 64'(occ), 64'h8);

    // 5: flush wins over a simultaneous request
    set_rng(0, 32'h7000, 32'h700F);
    req   = 2'b01;
    flush = 1'b1;
    #1 chk("t5_gnt0", 64'(gnt), 64'h0);
    tick();
    flush = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("t5_busy%0d", j), 64'(busy), 64'h1);
      chk($sformatf("t5_we%0d", j), 64'(we), 64'h1);
      chk($sformatf("t5_valid%0d", j), 64'(valid), 64'h0);
      chk($sformatf("t5_idx%0d", j), 64'(idx), 64'(j));
      chk($sformatf("t5_first%0d", j), 64'(bfirst), 64'h0);
      chk($sformatf("t5_gnt%0d", j), 64'(gnt), 64'h0);
      tick();
    end
    chk("t5_busy_end", 64'(busy), 64'h0);
    chk("t5_occ_end", 64'(occ), 64'h0);
    chk("t5_gnt_end", 64'(gnt), 64'h1);
    tick();
    req = 2'b00;
    chk("t5_we_post", 64'(we), 64'h1);
    chk("t5_idx_post", 64'(idx), 64'h0);
    chk("t5_valid_post", 64'(valid), 64'h1);
    chk("t5_first_post", 64'(bfirst), 64'h7000);
    chk("t5_occ_post", 64'(occ), 64'h1);
    chk("t5_drop_kept", 64'(drops), 64'h2);

    // Write granted just before a flush completes first
    set_rng(0, 32'h8000, 32'h800F);
    req = 2'b01;
    tick();
    req   = 2'b00;
    flush = 1'b1;
    chk("t5b_we", 64'(we), 64'h1);
    chk("t5b_idx", 64'(idx), 64'h1);
    chk("t5b_valid", 64'(valid), 64'h1);
    tick();
    flush = 1'b0;
    chk("t5b_fl_idx", 64'(idx), 64'h0);
    chk("t5b_fl_valid", 64'(valid), 64'h0);
    chk("t5b_busy", 64'(busy), 64'h1);

    // 6: reset during the third flush write
    tick();
    tick();
    chk("t6_idx2", 64'(idx), 64'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("t6");
    set_rng(0, 32'h9000, 32'h900F);
    req = 2'b01;
    #1 chk("t6_gnt", 64'(gnt), 64'h1);
    tick();
    req = 2'b00;
    chk("t6_we", 64'(we), 64'h1);
    chk("t6_idx", 64'(idx), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
